// File: rtl/regfile_pkg.sv
// Shared types and MIPS register index constants for the multi-port register file.
package regfile_pkg;

  // Post-reset / soft-clear sweep states
  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } clr_state_e;

  localparam int unsigned REG_ZERO = 0;
  localparam int unsigned REG_V0   = 2;
  localparam int unsigned REG_A0   = 4;
  localparam int unsigned REG_RA   = 31;

endpackage

// File: rtl/regfile_mp_if.sv
// Register file bus: read ports, write port, clear request, JR capture and syscall taps.
interface regfile_mp_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned NUM_RD = 2
);

  logic                       clr_req;
  logic [NUM_RD*ADDR_W-1:0]   rd_addr;
  logic [NUM_RD*DATA_W-1:0]   rd_data;
  logic                       wr_en;
  logic [ADDR_W-1:0]          wr_addr;
  logic [DATA_W-1:0]          wr_data;
  logic                       jr_capture;
  logic [DATA_W-1:0]          jr_target;
  logic                       ready;
  logic [DATA_W-1:0]          sys_call_reg;
  logic [DATA_W-1:0]          std_out_address;

  modport master (
    output clr_req, rd_addr, wr_en, wr_addr, wr_data, jr_capture,
    input  rd_data, jr_target, ready, sys_call_reg, std_out_address
  );

  modport slave (
    input  clr_req, rd_addr, wr_en, wr_addr, wr_data, jr_capture,
    output rd_data, jr_target, ready, sys_call_reg, std_out_address
  );

endinterface

// File: rtl/regfile_rd_mux.sv
// One read port: array data, optionally replaced by a same-cycle write, forced to zero for r0 or while not ready.
module regfile_rd_mux
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 1
) (
  input  logic              ready,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data_c
);

  // Priority: not-ready gate > zero entry > bypass > array
  always_comb begin
    rd_data_c = mem_data;
    if ((BYPASS != 0) && wr_en && (wr_addr == rd_addr)) rd_data_c = wr_data;
    if ((ZERO_REG != 0) && (rd_addr == ADDR_W'(REG_ZERO))) rd_data_c = '0;
    if (!ready) rd_data_c = '0;
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port MIPS register file with clear sweep, write bypass, JR target capture and syscall taps.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 1,
  parameter int unsigned V0_IDX   = REG_V0,
  parameter int unsigned A0_IDX   = REG_A0
) (
  input  logic         clk,
  input  logic         rst_n,
  regfile_mp_if.slave  bus
);

  localparam int unsigned       DEPTH    = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  logic [DATA_W-1:0] mem [DEPTH];

  clr_state_e        state, state_nxt;
  logic [ADDR_W-1:0] clr_idx, clr_idx_nxt;
  logic              ready_q;
  logic              jr_capture_q;
  logic [DATA_W-1:0] jr_target_q;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  logic [DATA_W-1:0] rd_arr [NUM_RD];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= CLEAR;
    else        state <= state_nxt;
  end

  // Next state: sweep ends after the last entry; a clear request restarts it
  always_comb begin
    state_nxt = state;
    case (state)
      CLEAR:   if (clr_idx == LAST_IDX) state_nxt = READY;
      READY:   if (bus.clr_req)         state_nxt = CLEAR;
      default: state_nxt = CLEAR;
    endcase
  end

  // Outputs: sweep writes zero, READY forwards the user write unless a clear or r0 blocks it
  always_comb begin
    mem_we      = 1'b0;
    mem_waddr   = bus.wr_addr;
    mem_wdata   = bus.wr_data;
    clr_idx_nxt = clr_idx;
    case (state)
      CLEAR: begin
        mem_we      = 1'b1;
        mem_waddr   = clr_idx;
        mem_wdata   = '0;
        clr_idx_nxt = clr_idx + ADDR_W'(1);
      end
      READY: begin
        if (bus.clr_req) begin
          clr_idx_nxt = '0;
        end else if (bus.wr_en &&
                     !((ZERO_REG != 0) && (bus.wr_addr == ADDR_W'(REG_ZERO)))) begin
          mem_we = 1'b1;
        end
      end
      default: clr_idx_nxt = '0;
    endcase
  end

  // Sweep index and ready flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clr_idx <= '0;
      ready_q <= 1'b0;
    end else begin
      clr_idx <= clr_idx_nxt;
      ready_q <= (state_nxt == READY);
    end
  end

  // Storage array; contents need no reset since the sweep clears every entry
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  // Per-port read select
  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    assign addr = bus.rd_addr[i*ADDR_W +: ADDR_W];
    regfile_rd_mux #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .ZERO_REG (ZERO_REG),
      .BYPASS   (BYPASS)
    ) u_rd_mux (
      .ready     (ready_q),
      .rd_addr   (addr),
      .mem_data  (mem[addr]),
      .wr_en     (bus.wr_en),
      .wr_addr   (bus.wr_addr),
      .wr_data   (bus.wr_data),
      .rd_data_c (rd_arr[i])
    );
  end

  // Pack per-port results onto the bus
  always_comb begin
    bus.rd_data = '0;
    for (int unsigned i = 0; i < NUM_RD; i++) begin
      bus.rd_data[i*DATA_W +: DATA_W] = rd_arr[i];
    end
  end

  // JR target: capture port 0 on a rising edge of jr_capture once the file is usable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      jr_capture_q <= 1'b0;
      jr_target_q  <= '0;
    end else begin
      jr_capture_q <= bus.jr_capture;
      if (ready_q && bus.jr_capture && !jr_capture_q) jr_target_q <= rd_arr[0];
    end
  end

  assign bus.ready           = ready_q;
  assign bus.jr_target       = jr_target_q;
  assign bus.sys_call_reg    = ready_q ? mem[ADDR_W'(V0_IDX)] : '0;
  assign bus.std_out_address = ready_q ? mem[ADDR_W'(A0_IDX)] : '0;

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboarded bench for regfile_mp: expected values queued at stimulus time, popped at observation.
module tb_regfile_mp;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned NR = 2;

  logic clk;
  logic rst_n;

  regfile_mp_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) bus ();

  regfile_mp #(
    .DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR),
    .ZERO_REG(1), .BYPASS(1), .V0_IDX(2), .A0_IDX(4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int unsigned vectors;
  int unsigned miscompares;
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] model [32];
  logic [DW-1:0] exp_v;
  logic [DW-1:0] got_v;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 32; i++) model[i] = '0;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.wr_en = 1'b1; bus.wr_addr = a; bus.wr_data = d;
    tick();
    bus.wr_en = 1'b0;
    if (a != 0) model[a] = d;
  endtask

  task automatic test_reset();
    int n;
    rst_n = 1'b0;
    bus.clr_req = 1'b0; bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.rd_addr = '0; bus.jr_capture = 1'b0;
    repeat (2) tick();
    vectors++;
    if (bus.ready !== 1'b0) begin
      miscompares++; $display("FAIL reset_ready got %b exp 0", bus.ready);
    end
    exp_q.push_back('0);
    exp_v = exp_q.pop_front(); vectors++;
    if (bus.jr_target !== exp_v) begin
      miscompares++; $display("FAIL reset_jr_target got %h exp %h", bus.jr_target, exp_v);
    end
    rst_n = 1'b1;
    model_clear();
    n = 0;
    while (bus.ready !== 1'b1 && n < 64) begin tick(); n++; end
    vectors++;
    if (n != 32) begin
      miscompares++; $display("FAIL reset_sweep_len got %0d exp 32", n);
    end
  endtask

  task automatic test_zero_all();
    for (int a = 0; a < 32; a++) begin
      bus.rd_addr = {AW'(31 - a), AW'(a)};
      exp_q.push_back(model[a]);
      exp_q.push_back(model[31 - a]);
      #1;
      exp_v = exp_q.pop_front(); got_v = bus.rd_data[31:0]; vectors++;
      if (got_v !== exp_v) begin
        miscompares++; $display("FAIL zero_all p0 a=%0d got %h exp %h", a, got_v, exp_v);
      end
      exp_v = exp_q.pop_front(); got_v = bus.rd_data[63:32]; vectors++;
      if (got_v !== exp_v) begin
        miscompares++; $display("FAIL zero_all p1 a=%0d got %h exp %h", 31 - a, got_v, exp_v);
      end
    end
  endtask

  task automatic test_wr_rd();
    bus.rd_addr = {AW'(0), AW'(5)};
    do_write(5'd5, 32'hDEADBEEF);
    exp_q.push_back(32'hDEADBEEF);
    #1;
    exp_v = exp_q.pop_front(); got_v = bus.rd_data[31:0]; vectors++;
    if (got_v !== exp_v) begin
      miscompares++; $display("FAIL wr_rd r5 got %h exp %h", got_v, exp_v);
    end
  endtask

  task automatic test_bypass();
    bus.wr_en = 1'b1; bus.wr_addr = 5'd7; bus.wr_data = 32'h1234;
    bus.rd_addr = {AW'(7), AW'(7)};
    exp_q.push_back(32'h1234);
    exp_q.push_back(32'h1234);
    #1;
    exp_v = exp_q.pop_front(); got_v = bus.rd_data[63:32]; vectors++;
    if (got_v !== exp_v) begin
      miscompares++; $display("FAIL bypass p1 got %h exp %h", got_v, exp_v);
    end
    exp_v = exp_q.pop_front(); got_v = bus.rd_data[31:0]; vectors++;
    if (got_v !== exp_v) begin
      miscompares++; $display("FAIL bypass p0 got %h exp %h", got_v, exp_v);
    end
    tick();
    bus.wr_en = 1'b0;
    model[7] = 32'h1234;
    bus.rd_addr = {AW'(5), AW'(7)};
    exp_q.push_back(model[7]);
    exp_q.push_back(model[5]);
    #1;
    exp_v = exp_q.pop_front(); got_v = bus.rd_data[31:0]; vectors++;
    if (got_v !== exp_v) begin
      miscompares++; $display("FAIL bypass_stored r7 got %h exp %h", got_v, exp_v);
    end
    exp_v = exp_q.pop_front(); got_v = bus.rd_data[63:32]; vectors++;
    if (got_v !== exp_v) begin
      miscompares++; $display("FAIL bypass_stored r5 got %h exp %h", got_v, exp_v);
    end
  endtask

  task automatic test_zero_reg();
    bus.wr_en = 1'b1; bus.wr_addr = 5'd0; bus.wr_data = 32'hFFFFFFFF;
    bus.rd_addr = {AW'(0), AW'(0)};
    exp_q.push_back('0);
    #1;
    exp_v = exp_q.pop_front(); got_v = bus.rd_data[31:0]; vectors++;
    if (got_v !== exp_v) begin
      miscompares++; $display("FAIL zero_bypass r0 got %h exp %h", got_v, exp_v);
    end
    tick();
    bus.wr_en = 1'b0;
    exp_q.push_back('0);
    #1;
    exp_v = exp_q.pop_front(); got_v = bus.rd_data[63:32]; vectors++;
    if (got_v !== exp_v) begin
      miscompares++; $display("FAIL zero_reg r0 got %h exp %h", got_v, exp_v);
    end
  endtask

  task automatic test_syscall();
    bus.wr_en = 1'b1; bus.wr_addr = 5'd2; bus.wr_data = 32'd10;
    exp_q.push_back(model[2]);
    #1;
    exp_v = exp_q.pop_front(); vectors++;
    if (bus.sys_call_reg !== exp_v) begin
      miscompares++; $display("FAIL tap_no_bypass got %h exp %h", bus.sys_call_reg, exp_v);
    end
    tick();
    model[2] = 32'd10;
    bus.wr_addr = 5'd4; bus.wr_data = 32'h1000;
    exp_q.push_back(model[2]);
    exp_v = exp_q.pop_front(); vectors++;
    if (bus.sys_call_reg !== exp_v) begin
      miscompares++; $display("FAIL tap_v0 got %h exp %h", bus.sys_call_reg, exp_v);
    end
    tick();
    bus.wr_en = 1'b0;
    model[4] = 32'h1000;
    exp_q.push_back(model[4]);
    exp_v = exp_q.pop_front(); vectors++;
    if (bus.std_out_address !== exp_v) begin
      miscompares++; $display("FAIL tap_a0 got %h exp %h", bus.std_out_address, exp_v);
    end
  endtask

  task automatic test_jr();
    logic [DW-1:0] held;
    do_write(5'd31, 32'h00400020);
    bus.rd_addr = {AW'(0), AW'(31)};
    bus.jr_capture = 1'b0;
    tick();
    bus.jr_capture = 1'b1;
    exp_q.push_back('0);
    #1;
    exp_v = exp_q.pop_front(); vectors++;
    if (bus.jr_target !== exp_v) begin
      miscompares++; $display("FAIL jr_latency got %h exp %h", bus.jr_target, exp_v);
    end
    tick();
    exp_q.push_back(model[31]);
    exp_v = exp_q.pop_front(); vectors++;
    if (bus.jr_target !== exp_v) begin
      miscompares++; $display("FAIL jr_capture got %h exp %h", bus.jr_target, exp_v);
    end
    held = model[31];
    do_write(5'd31, 32'hCAFEF00D);
    repeat (4) tick();
    exp_q.push_back(held);
    exp_v = exp_q.pop_front(); vectors++;
    if (bus.jr_target !== exp_v) begin
      miscompares++; $display("FAIL jr_hold got %h exp %h", bus.jr_target, exp_v);
    end
    bus.jr_capture = 1'b0;
    tick();
    bus.jr_capture = 1'b1;
    tick();
    bus.jr_capture = 1'b0;
    exp_q.push_back(model[31]);
    exp_v = exp_q.pop_front(); vectors++;
    if (bus.jr_target !== exp_v) begin
      miscompares++; $display("FAIL jr_recapture got %h exp %h", bus.jr_target, exp_v);
    end
  endtask

  task automatic test_clear();
    int n;
    logic [DW-1:0] jr_before;
    jr_before = bus.jr_target;
    bus.rd_addr = {AW'(2), AW'(5)};
    bus.clr_req = 1'b1; bus.wr_en = 1'b1; bus.wr_addr = 5'd3; bus.wr_data = 32'h33;
    tick();
    bus.clr_req = 1'b0; bus.wr_en = 1'b0;
    vectors++;
    if (bus.ready !== 1'b0) begin
      miscompares++; $display("FAIL clear_ready_drop got %b exp 0", bus.ready);
    end
    exp_q.push_back('0);
    exp_q.push_back('0);
    exp_v = exp_q.pop_front(); got_v = bus.rd_data[31:0]; vectors++;
    if (got_v !== exp_v) begin
      miscompares++; $display("FAIL clear_rd_gate got %h exp %h", got_v, exp_v);
    end
    exp_v = exp_q.pop_front(); vectors++;
    if (bus.sys_call_reg !== exp_v) begin
      miscompares++; $display("FAIL clear_tap_gate got %h exp %h", bus.sys_call_reg, exp_v);
    end
    model_clear();
    n = 0;
    while (bus.ready !== 1'b1 && n < 64) begin
      if (n == 20) begin
        bus.wr_en = 1'b1; bus.wr_addr = 5'd1; bus.wr_data = 32'h11;
      end else begin
        bus.wr_en = 1'b0;
      end
      if (n == 25) bus.jr_capture = 1'b1;
      if (n == 27) bus.jr_capture = 1'b0;
      tick();
      n++;
    end
    bus.wr_en = 1'b0;
    vectors++;
    if (n != 32) begin
      miscompares++; $display("FAIL clear_sweep_len got %0d exp 32", n);
    end
    exp_q.push_back(jr_before);
    exp_v = exp_q.pop_front(); vectors++;
    if (bus.jr_target !== exp_v) begin
      miscompares++; $display("FAIL clear_jr_ignored got %h exp %h", bus.jr_target, exp_v);
    end
    for (int k = 0; k < 3; k++) begin
      logic [AW-1:0] a;
      a = (k == 0) ? AW'(3) : (k == 1) ? AW'(5) : AW'(1);
      bus.rd_addr = {AW'(0), a};
      exp_q.push_back(model[a]);
      #1;
      exp_v = exp_q.pop_front(); got_v = bus.rd_data[31:0]; vectors++;
      if (got_v !== exp_v) begin
        miscompares++; $display("FAIL clear_contents r%0d got %h exp %h", a, got_v, exp_v);
      end
    end
  endtask

  task automatic test_reset_mid();
    int n;
    do_write(5'd9, 32'h99);
    bus.clr_req = 1'b1;
    tick();
    bus.clr_req = 1'b0;
    repeat (10) tick();
    rst_n = 1'b0;
    #1;
    vectors++;
    if (bus.ready !== 1'b0) begin
      miscompares++; $display("FAIL midrst_ready got %b exp 0", bus.ready);
    end
    exp_q.push_back('0);
    exp_v = exp_q.pop_front(); vectors++;
    if (bus.jr_target !== exp_v) begin
      miscompares++; $display("FAIL midrst_jr got %h exp %h", bus.jr_target, exp_v);
    end
    tick();
    rst_n = 1'b1;
    model_clear();
    n = 0;
    while (bus.ready !== 1'b1 && n < 64) begin tick(); n++; end
    vectors++;
    if (n != 32) begin
      miscompares++; $display("FAIL midrst_sweep_len got %0d exp 32", n);
    end
    bus.rd_addr = {AW'(9), AW'(5)};
    exp_q.push_back(model[5]);
    exp_q.push_back(model[9]);
    #1;
    exp_v = exp_q.pop_front(); got_v = bus.rd_data[31:0]; vectors++;
    if (got_v !== exp_v) begin
      miscompares++; $display("FAIL midrst_r5 got %h exp %h", got_v, exp_v);
    end
    exp_v = exp_q.pop_front(); got_v = bus.rd_data[63:32]; vectors++;
    if (got_v !== exp_v) begin
      miscompares++; $display("FAIL midrst_r9 got %h exp %h", got_v, exp_v);
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_zero_all();
    test_wr_rd();
    test_bypass();
    test_zero_reg();
    test_syscall();
    test_jr();
    test_clear();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
